apb_req_master: RTL and testbench

//   Request-to-APB bridge: accepts 16-bit addr/data requests from the test/control

---
 rtl/apb_req_master.sv | 236 +++++++++++++++++++++++
 tb/tb_apb_req_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// apb_req_master: request FIFO feeding a byte-wide APB master; WIDE requests become two transfers.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT cycles.
module apb_req_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [15:0] addr_req,
  input  logic        req,
  input  logic        wr_req,
  input  logic [15:0] data_send,
  output logic        ack,
  output logic [15:0] data_reciv,
  output logic        complete,
  output logic        busy,
  output logic        err,
  output logic [7:0]  paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [7:0]  pwdata,
  input  logic [7:0]  prdata,
  input  logic        pready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 26;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  // Entry layout: {wide, addr[7:0], wr, data[15:0]}
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [EW-1:0] head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          push, pop, full;

  logic [7:0]    addr_q, addr_d;
  logic          wide_q, wide_d;
  logic          wr_q, wr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [7:0]    rbyte0_q, rbyte0_d;
  logic          idx_q, idx_d;

  logic [15:0]   data_reciv_q, data_reciv_d;
  logic          complete_q, complete_d;
  logic [7:0]    paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic [7:0]    pwdata_q, pwdata_d;

  logic [6:0]    unused_addr_hi;
  assign unused_addr_hi = addr_req[15:9];

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  assign err = err_q;
`else
  logic [31:0]   unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign err = 1'b0;
`endif

  // The head entry stays in the FIFO until its transfer finishes, so the
  // depth bounds the total number of outstanding requests.
  assign head = fifo_mem[rd_ptr_q];
  assign full = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop  = (state_q == DONE);
  assign push = req && !ack_q && (!full || pop);

  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr_q] <= {addr_req[8:0], wr_req, data_send};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ack_d    = push;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wide_d       = wide_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    rbyte0_d     = rbyte0_q;
    idx_d        = idx_q;
    data_reciv_d = data_reciv_q;
    complete_d   = 1'b0;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwdata_d     = pwdata_q;
`ifdef APB_TIMEOUT_EN
    tmr_d        = tmr_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          wide_d    = head[25];
          addr_d    = head[24:17];
          wr_d      = head[16];
          wdata_d   = head[15:0];
          idx_d     = 1'b0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = head[24:17];
          pwrite_d  = head[16];
          pwdata_d  = head[7:0];
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        tmr_d     = '0;
`endif
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          if (!wr_q && !idx_q) rbyte0_d = prdata;
          if (wide_q && !idx_q) begin
            idx_d     = 1'b1;
            penable_d = 1'b0;
            paddr_d   = addr_q + 8'd1;
            pwdata_d  = wdata_q[15:8];
            state_d   = SETUP;
          end else begin
            psel_d     = 1'b0;
            penable_d  = 1'b0;
            complete_d = 1'b1;
            if (!wr_q) data_reciv_d = wide_q ? {prdata, rbyte0_q} : {8'h00, prdata};
            state_d    = DONE;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (tmr_q == TW'(TIMEOUT - 1)) begin
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          complete_d = 1'b1;
          err_d      = 1'b1;
          if (!wr_q) data_reciv_d = 16'hFFFF;
          state_d    = DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ack_q        <= 1'b0;
      state_q      <= IDLE;
      addr_q       <= '0;
      wide_q       <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      rbyte0_q     <= '0;
      idx_q        <= 1'b0;
      data_reciv_q <= '0;
      complete_q   <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwdata_q     <= '0;
`ifdef APB_TIMEOUT_EN
      tmr_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ack_q        <= ack_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      wide_q       <= wide_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      rbyte0_q     <= rbyte0_d;
      idx_q        <= idx_d;
      data_reciv_q <= data_reciv_d;
      complete_q   <= complete_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwdata_q     <= pwdata_d;
`ifdef APB_TIMEOUT_EN
      tmr_q        <= tmr_d;
      err_q        <= err_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign data_reciv = data_reciv_q;
  assign complete   = complete_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);
  assign paddr      = paddr_q;
  assign pwrite     = pwrite_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwdata     = pwdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed testbench for apb_req_master with a small APB slave responder and transfer logs.
// The timeout scenario runs only when APB_TIMEOUT_EN is defined.
module tb_apb_req_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic [15:0] addr_req;
  logic        req;
  logic        wr_req;
  logic [15:0] data_send;
  logic        ack;
  logic [15:0] data_reciv;
  logic        complete;
  logic        busy;
  logic        err;
  logic [7:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;

  always #5 pclk = ~pclk;

  apb_req_master #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .addr_req   (addr_req),
    .req        (req),
    .wr_req     (wr_req),
    .data_send  (data_send),
    .ack        (ack),
    .data_reciv (data_reciv),
    .complete   (complete),
    .busy       (busy),
    .err        (err),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave responder: pready after wait_states extra ACCESS cycles, read bytes from rd_bytes
  int         wait_states = 0;
  logic       slave_en = 1'b1;
  logic [7:0] rd_bytes [64];
  int         rd_idx = 0;
  int         acc_cnt = 0;

  assign pready = slave_en && psel && penable && (acc_cnt >= wait_states);
  assign prdata = rd_bytes[rd_idx % 64];

  int         n_xfer = 0;
  logic [7:0] xa [64];
  logic [7:0] xd [64];
  logic       xw [64];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready) begin
      xa[n_xfer % 64] <= paddr;
      xd[n_xfer % 64] <= pwdata;
      xw[n_xfer % 64] <= pwrite;
      n_xfer <= n_xfer + 1;
      if (!pwrite) rd_idx <= rd_idx + 1;
    end
  end

  int          n_cmp = 0;
  int          n_ack = 0;
  int          n_pen = 0;
  logic [15:0] cd [64];
  logic        ce [64];

  always @(negedge pclk) begin
    if (complete) begin
      cd[n_cmp % 64] <= data_reciv;
      ce[n_cmp % 64] <= err;
      n_cmp <= n_cmp + 1;
    end
    if (ack) n_ack <= n_ack + 1;
    if (psel && penable) n_pen <= n_pen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input logic [15:0] a, input logic w, input logic [15:0] d);
    addr_req  = a;
    wr_req    = w;
    data_send = d;
    req       = 1'b1;
  endtask

  task automatic wait_ack(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (ack) begin
        got = 1'b1;
        req = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_cmp(input int target, input int max_cycles, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (n_cmp >= target) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, got, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit got;
    bit found;
    bit stable;
    int b_x, b_c, b_a, b_p;

    for (int i = 0; i < 64; i++) rd_bytes[i] = 8'h00;
    preset    = 1'b1;
    req       = 1'b0;
    wr_req    = 1'b0;
    addr_req  = 16'h0000;
    data_send = 16'h0000;
    repeat (3) tick();
    preset = 1'b0;
    tick();

    // Reset state
    check_eq("rst_psel", psel, 0);
    check_eq("rst_penable", penable, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_complete", complete, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_paddr", paddr, 0);
    check_eq("rst_data_reciv", data_reciv, 0);
    check_eq("rst_err", err, 0);

    // 1: single write, pready in first ACCESS cycle
    set_req(16'h0003, 1'b1, 16'h0001);
    wait_ack(10, got);
    check_eq("t1_ack", got, 1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (psel && !penable) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("t1_setup_seen", found, 1);
    check_eq("t1_setup_paddr", paddr, 8'h03);
    tick();
    check_eq("t1_access_psel_penable", {psel, penable}, 2'b11);
    check_eq("t1_access_paddr", paddr, 8'h03);
    check_eq("t1_access_pwdata", pwdata, 8'h01);
    check_eq("t1_access_pwrite", pwrite, 1);
    tick();
    check_eq("t1_complete", complete, 1);
    check_eq("t1_done_psel", psel, 0);
    check_eq("t1_write_keeps_data_reciv", data_reciv, 16'h0000);

    // 2: WIDE read at 0xFF, address wraps to 0x00
    tick();
    rd_bytes[rd_idx % 64]       = 8'h5A;
    rd_bytes[(rd_idx + 1) % 64] = 8'hC3;
    b_x = n_xfer;
    b_c = n_cmp;
    set_req(16'h01FF, 1'b0, 16'h0000);
    wait_ack(10, got);
    check_eq("t2_ack", got, 1);
    wait_cmp(b_c + 1, 50, "t2_completed");
    check_eq("t2_xfer_count", n_xfer - b_x, 2);
    check_eq("t2_paddr0", xa[b_x % 64], 8'hFF);
    check_eq("t2_paddr1", xa[(b_x + 1) % 64], 8'h00);
    check_eq("t2_pwrite0", xw[b_x % 64], 0);
    check_eq("t2_cmp_data", cd[b_c % 64], 16'hC35A);
    check_eq("t2_cmp_err", ce[b_c % 64], 0);
    tick();
    check_eq("t2_data_reciv_held", data_reciv, 16'hC35A);

    // 4: read with 3 wait states
    wait_states = 3;
    rd_bytes[rd_idx % 64] = 8'h77;
    b_x = n_xfer;
    b_c = n_cmp;
    b_p = n_pen;
    set_req(16'h0010, 1'b0, 16'h0000);
    wait_ack(10, got);
    check_eq("t4_ack", got, 1);
    stable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (psel && paddr != 8'h10) stable = 1'b0;
      if (n_cmp > b_c) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("t4_completed", got, 1);
    check_eq("t4_paddr_stable", stable, 1);
    check_eq("t4_penable_cycles", n_pen - b_p, 4);
    check_eq("t4_paddr", xa[b_x % 64], 8'h10);
    check_eq("t4_cmp_data", cd[b_c % 64], 16'h0077);
    wait_states = 0;

    // 3: five back-to-back writes with the slave stalled
    tick();
    slave_en = 1'b0;
    b_x = n_xfer;
    b_c = n_cmp;
    b_a = n_ack;
    for (int i = 0; i < 4; i++) begin
      set_req(16'h0030 + 16'(i), 1'b1, 16'h00A0 + 16'(i));
      wait_ack(10, got);
      check_eq($sformatf("t3_ack%0d", i), got, 1);
    end
    set_req(16'h0034, 1'b1, 16'h00A4);
    repeat (20) tick();
    check_eq("t3_acks_while_stalled", n_ack - b_a, 4);
    check_eq("t3_ack4_withheld", ack, 0);
    slave_en = 1'b1;
    wait_ack(30, got);
    check_eq("t3_ack4", got, 1);
    check_eq("t3_cmps_before_ack4", n_cmp - b_c, 1);
    wait_cmp(b_c + 5, 100, "t3_all_completed");
    check_eq("t3_xfer_count", n_xfer - b_x, 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t3_order_addr%0d", i), xa[(b_x + i) % 64], 8'h30 + 8'(i));
      check_eq($sformatf("t3_order_data%0d", i), xd[(b_x + i) % 64], 8'hA0 + 8'(i));
    end
    tick();
    check_eq("t3_data_reciv_unchanged", data_reciv, 16'h0077);

    // 5: reset during ACCESS with two requests queued
    slave_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(16'h0050 + 16'(i), 1'b0, 16'h0000);
      wait_ack(10, got);
      check_eq($sformatf("t5_ack%0d", i), got, 1);
    end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (psel && penable) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("t5_in_access", found, 1);
    preset = 1'b1;
    tick();
    check_eq("t5_psel_dropped", psel, 0);
    check_eq("t5_penable_dropped", penable, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_no_complete", complete, 0);
    check_eq("t5_data_reciv_cleared", data_reciv, 16'h0000);
    preset = 1'b0;
    b_c = n_cmp;
    b_p = n_pen;
    slave_en = 1'b1;
    repeat (10) tick();
    check_eq("t5_no_late_complete", n_cmp - b_c, 0);
    check_eq("t5_bus_quiet", n_pen - b_p, 0);
    check_eq("t5_still_idle", busy, 0);
    rd_bytes[rd_idx % 64] = 8'h9C;
    b_x = n_xfer;
    set_req(16'h0022, 1'b0, 16'h0000);
    wait_ack(10, got);
    check_eq("t5_post_ack", got, 1);
    wait_cmp(b_c + 1, 50, "t5_post_completed");
    repeat (5) tick();
    check_eq("t5_post_single_cmp", n_cmp - b_c, 1);
    check_eq("t5_post_xfer_count", n_xfer - b_x, 1);
    check_eq("t5_post_paddr", xa[b_x % 64], 8'h22);
    check_eq("t5_post_data", data_reciv, 16'h009C);

`ifdef APB_TIMEOUT_EN
    // 6: read with pready never asserted, aborted after 8 ACCESS cycles
    slave_en = 1'b0;
    b_x = n_xfer;
    b_c = n_cmp;
    b_p = n_pen;
    set_req(16'h0040, 1'b0, 16'h0000);
    wait_ack(10, got);
    check_eq("t6_ack", got, 1);
    wait_cmp(b_c + 1, 50, "t6_completed");
    check_eq("t6_err", ce[b_c % 64], 1);
    check_eq("t6_data", cd[b_c % 64], 16'hFFFF);
    check_eq("t6_access_cycles", n_pen - b_p, 8);
    check_eq("t6_no_handshake", n_xfer - b_x, 0);
    tick();
    check_eq("t6_err_pulse", err, 0);
    check_eq("t6_psel", psel, 0);
    slave_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
